// File: rtl/exanet_crosb_pkg.sv
// Shared types for the crossbar-stream to exanet-link bridge.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package exanet_crosb_pkg;

   localparam int TDATA_W = 128;

   // Beat classification carried alongside the data through the skid buffer.
   typedef enum logic [1:0] {
      TAG_HDR = 2'd0,
      TAG_PAY = 2'd1,
      TAG_FTR = 2'd2
   } beat_tag_e;

   // Packet framing state: IDLE means the next accepted beat is a header.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } fsm_state_e;

   typedef struct packed {
      beat_tag_e            tag;
      logic [TDATA_W-1:0]   dat;
   } beat_t;

   localparam int BEAT_W = $bits(beat_t);

   // Tag of a beat accepted in the given framing state.
   function automatic beat_tag_e beat_tag(input fsm_state_e st, input logic last);
      beat_tag_e t;
      if (st == ST_IDLE) begin
         t = TAG_HDR;
      end else if (last) begin
         t = TAG_FTR;
      end else begin
         t = TAG_PAY;
      end
      return t;
   endfunction

endpackage

// File: rtl/exa_s2e_skid.sv
// Two-entry valid/ready buffer decoupling the stream input from the link output.
// Latency: 1 cycle from push to output valid when empty; sustains 1 beat/cycle.
// Backpressure: input ready drops only when both entries are occupied.
module exa_s2e_skid #(
   parameter int DWIDTH = 130
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DWIDTH-1:0] i_in_dat,
   input  logic              i_in_vld,
   output logic              o_in_rdy,
   output logic [DWIDTH-1:0] o_out_dat,
   output logic              o_out_vld,
   input  logic              i_out_rdy
);

   logic [DWIDTH-1:0] r_mem [0:1];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_cnt;
   logic              w_push;
   logic              w_pop;

   assign o_in_rdy  = (r_cnt != 2'd2);
   assign o_out_vld = (r_cnt != 2'd0);
   assign o_out_dat = r_mem[r_rptr];
   assign w_push    = i_in_vld & o_in_rdy;
   assign w_pop     = o_out_vld & i_out_rdy;

   // Storage needs no reset: an entry is only read once the count covers it.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_in_dat;
      end
   end

   // Pointers and occupancy; reset empties the buffer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_cnt  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/exa_crosb_s2e_with_vcs.sv
// Frames crossbar stream packets into exanet header/payload/footer beats with per-VC credit gating.
// Latency: 1 cycle input accept to exanet_tx valid when the buffer is empty; 1 beat/cycle throughput.
// Backpressure: TREADY low when the 2-entry buffer is full or the packet VC has no credit.
module exa_crosb_s2e_with_vcs
   import exanet_crosb_pkg::*;
#(
   parameter  int    prio_num   = 2,
   parameter  int    vc_num     = 2,
   parameter  int    credit_max = 40,
   parameter  string DEBUG      = "false",
   localparam int    NVC        = prio_num * vc_num,
   localparam int    CW         = $clog2(credit_max + 1)
) (
   input  logic                     M_ACLK,
   input  logic                     M_ARESETN,
   // crossbar output stream
   input  logic [TDATA_W-1:0]       S_AXIS_TDATA,
   input  logic                     S_AXIS_TLAST,
   input  logic                     S_AXIS_TVALID,
   output logic                     S_AXIS_TREADY,
   // link transmit side
   output logic [TDATA_W-1:0]       exanet_tx_data,
   output logic                     exanet_tx_header_valid,
   input  logic                     exanet_tx_header_ready,
   output logic                     exanet_tx_payload_valid,
   input  logic                     exanet_tx_payload_ready,
   output logic                     exanet_tx_footer_valid,
   input  logic                     exanet_tx_footer_ready,
   // credits
   input  logic [NVC-1:0]           i_credit_return,
   output logic [NVC-1:0][CW-1:0]   o_credits,
   output logic [NVC-1:0]           o_vc_ready,
   output logic                     o_proto_error,
   output logic                     o_credit_overflow
);

   localparam int            VCW    = (NVC > 1) ? $clog2(NVC) : 1;
   localparam logic [CW-1:0] C_MAX  = CW'(credit_max);
   localparam bit            DBG_EN = (DEBUG == "true");

   fsm_state_e            r_state;
   fsm_state_e            w_state_nxt;
   logic [VCW-1:0]        r_vc;
   logic [VCW-1:0]        w_vc_nxt;
   logic [VCW-1:0]        w_vc;
   logic                  r_rdy_en;
   logic [NVC-1:0][CW-1:0] r_credit;
   logic                  r_perr;
   logic                  r_ovf;
   logic                  w_perr_set;
   logic                  w_ovf_hit;
   logic                  w_cred_nz;
   logic [NVC-1:0]        w_dec;
   logic                  w_accept;
   beat_t                 w_in_beat;
   beat_t                 w_head;
   logic [BEAT_W-1:0]     w_skid_out_dat;
   logic                  w_skid_out_vld;
   logic                  w_skid_out_rdy;
   logic                  w_skid_in_rdy;

   // In IDLE the VC comes straight off the header beat; inside a packet it is the latched one.
   assign w_vc     = (r_state == ST_IDLE) ? S_AXIS_TDATA[VCW-1:0] : r_vc;
   assign w_accept = S_AXIS_TVALID & S_AXIS_TREADY;

   assign S_AXIS_TREADY = r_rdy_en & w_skid_in_rdy & w_cred_nz;

   // Credit availability of the VC the current beat belongs to (out-of-range VC never ready).
   always_comb begin
      w_cred_nz = 1'b0;
      for (int k = 0; k < NVC; k++) begin
         if (w_vc == VCW'(k)) begin
            w_cred_nz = (r_credit[k] != '0);
         end
      end
   end

   // One-hot credit consumption for the beat being accepted this cycle.
   always_comb begin
      w_dec = '0;
      for (int k = 0; k < NVC; k++) begin
         w_dec[k] = w_accept && (w_vc == VCW'(k));
      end
   end

   // A return that cannot be absorbed (already at max, nothing consumed) flags overflow.
   always_comb begin
      w_ovf_hit = 1'b0;
      for (int k = 0; k < NVC; k++) begin
         if (i_credit_return[k] && !w_dec[k] && (r_credit[k] == C_MAX)) begin
            w_ovf_hit = 1'b1;
         end
      end
   end

   // Framing next-state: headers open a packet unless they carry TLAST, which is an error.
   always_comb begin
      w_state_nxt = r_state;
      w_vc_nxt    = r_vc;
      w_perr_set  = 1'b0;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (S_AXIS_TLAST) begin
                  w_perr_set = 1'b1;
               end else begin
                  w_state_nxt = ST_XFER;
                  w_vc_nxt    = w_vc;
               end
            end
            ST_XFER: begin
               if (S_AXIS_TLAST) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Framing state and latched VC; reset drops any partial packet.
   always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
      if (!M_ARESETN) begin
         r_state <= ST_IDLE;
         r_vc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_vc    <= w_vc_nxt;
      end
   end

   // Input is held off for the first cycle after reset release.
   always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
      if (!M_ARESETN) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   // Per-VC credit counters: consume on accept, restore on return, saturate at max.
   always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
      if (!M_ARESETN) begin
         for (int k = 0; k < NVC; k++) begin
            r_credit[k] <= C_MAX;
         end
      end else begin
         for (int k = 0; k < NVC; k++) begin
            case ({w_dec[k], i_credit_return[k]})
               2'b10: r_credit[k] <= r_credit[k] - CW'(1);
               2'b01: begin
                  if (r_credit[k] != C_MAX) begin
                     r_credit[k] <= r_credit[k] + CW'(1);
                  end
               end
               default: r_credit[k] <= r_credit[k];
            endcase
         end
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge M_ACLK or negedge M_ARESETN) begin
      if (!M_ARESETN) begin
         r_perr <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_perr <= r_perr | w_perr_set;
         r_ovf  <= r_ovf | w_ovf_hit;
      end
   end

   assign w_in_beat.tag = beat_tag(r_state, S_AXIS_TLAST);
   assign w_in_beat.dat = S_AXIS_TDATA;

   exa_s2e_skid #(
      .DWIDTH (BEAT_W)
   ) u_skid (
      .i_clk     (M_ACLK),
      .i_rst_n   (M_ARESETN),
      .i_in_dat  (w_in_beat),
      .i_in_vld  (w_accept),
      .o_in_rdy  (w_skid_in_rdy),
      .o_out_dat (w_skid_out_dat),
      .o_out_vld (w_skid_out_vld),
      .i_out_rdy (w_skid_out_rdy)
   );

   assign w_head = beat_t'(w_skid_out_dat);

   assign exanet_tx_data          = w_head.dat;
   assign exanet_tx_header_valid  = w_skid_out_vld && (w_head.tag == TAG_HDR);
   assign exanet_tx_payload_valid = w_skid_out_vld && (w_head.tag == TAG_PAY);
   assign exanet_tx_footer_valid  = w_skid_out_vld && (w_head.tag == TAG_FTR);

   // Head of buffer leaves only on the ready that matches its own tag.
   always_comb begin
      w_skid_out_rdy = 1'b0;
      case (w_head.tag)
         TAG_HDR: w_skid_out_rdy = exanet_tx_header_ready;
         TAG_PAY: w_skid_out_rdy = exanet_tx_payload_ready;
         TAG_FTR: w_skid_out_rdy = exanet_tx_footer_ready;
         default: w_skid_out_rdy = 1'b0;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NVC; k++) begin
         o_vc_ready[k] = (r_credit[k] != '0);
      end
   end

   assign o_credits         = r_credit;
   assign o_proto_error     = r_perr;
   assign o_credit_overflow = r_ovf;

   // Debug builds expose the framing state under a mark_debug attribute.
   if (DBG_EN) begin : g_debug
      (* mark_debug = "true" *) fsm_state_e w_dbg_state;
      assign w_dbg_state = r_state;
   end

endmodule
